// File: rtl/io_bus_ctrl.sv
// I/O bus controller: decodes the I/O page into slave slots, runs a per-access
// slave handshake with stall, registered read data and timeout error reporting.
module io_bus_ctrl #(
  parameter int                AW      = 24,
  parameter int                DW      = 32,
  parameter int                SLW     = 4,
  parameter int                NSLV    = 16,
  parameter logic [AW-SLW-3:0] IO_PFX  = 18'h3FFFF,
  parameter int                TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      adr,
  input  logic               rd,
  input  logic               wr,
  input  logic [DW-1:0]      din,
  input  logic [DW-1:0]      mem_rdata,
  output logic [DW-1:0]      dout,
  output logic               stall,
  output logic [NSLV-1:0]    slv_en,
  output logic               slv_rd,
  output logic               slv_wr,
  output logic [DW-1:0]      slv_wdata,
  input  logic [NSLV*DW-1:0] slv_rdata,
  input  logic [NSLV-1:0]    slv_ack,
  output logic               err,
  input  logic               err_clr,
  output logic [7:0]         err_cnt
);

  localparam int             CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [SLW:0]   NSLV_W = (SLW+1)'(NSLV);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [SLW-1:0]  slot_q;
  logic [DW-1:0]   rdata_q;
  logic [CW-1:0]   cnt;

  logic            io_sel;
  logic [SLW-1:0]  slot;
  logic            slot_ok;
  logic [NSLV-1:0] onehot;
  logic            sel_ack;
  logic [DW-1:0]   sel_rdata;
  logic            new_err;

  assign io_sel  = (adr[AW-1:SLW+2] == IO_PFX) && (rd || wr);
  assign slot    = adr[SLW+1:2];
  assign slot_ok = {1'b0, slot} < NSLV_W;

  // Only the latched slot's ack and data are looked at; other acks are ignored.
  always_comb begin
    onehot    = '0;
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      onehot[i] = (slot == SLW'(i));
      if (slot_q == SLW'(i)) begin
        sel_ack   = slv_ack[i];
        sel_rdata = slv_rdata[i*DW +: DW];
      end
    end
  end

  assign stall   = ((state == IDLE) && io_sel) || (state == ACCESS);
  assign dout    = io_sel ? rdata_q : mem_rdata;
  assign new_err = ((state == IDLE) && io_sel && !slot_ok) ||
                   ((state == ACCESS) && !sel_ack && (cnt == CNT_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot_q    <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
      slv_en    <= '0;
      slv_rd    <= 1'b0;
      slv_wr    <= 1'b0;
      slv_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_sel) begin
            if (slot_ok) begin
              slot_q    <= slot;
              slv_en    <= onehot;
              slv_rd    <= rd;
              slv_wr    <= wr;
              slv_wdata <= din;
              cnt       <= '0;
              state     <= ACCESS;
            end else begin
              rdata_q <= '0;
              state   <= DONE;
            end
          end
        end
        ACCESS: begin
          if (sel_ack || (cnt == CNT_LAST)) begin
            if (!sel_ack)
              rdata_q <= '0;
            else if (slv_rd)
              rdata_q <= sel_rdata;
            slv_en <= '0;
            slv_rd <= 1'b0;
            slv_wr <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as err_clr restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (new_err) begin
      err <= 1'b1;
      if (err_clr)
        err_cnt <= 8'd1;
      else if (err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: RAM pass-through, slave read/write, timeout,
// unimplemented slots with error counting, and reset during an access.
module tb_io_bus_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [23:0]  adr;
  logic         rd, wr;
  logic [31:0]  din, mem_rdata, dout;
  logic         stall;
  logic [15:0]  slv_en;
  logic         slv_rd, slv_wr;
  logic [31:0]  slv_wdata;
  logic [511:0] slv_rdata;
  logic [15:0]  slv_ack;
  logic         err, err_clr;
  logic [7:0]   err_cnt;

  logic [23:0]  adr4;
  logic         rd4, wr4, err_clr4, stall4, slv_rd4, slv_wr4, err4;
  logic [31:0]  dout4, slv_wdata4;
  logic [3:0]   slv_en4, slv_ack4;
  logic [127:0] slv_rdata4;
  logic [7:0]   err_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_stall;
  logic [31:0] done_dout, seen_wdata;
  logic [15:0] seen_en;
  logic        seen_rd, seen_wr, finished;

  always #5 clk = ~clk;

  io_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .adr(adr), .rd(rd), .wr(wr), .din(din),
    .mem_rdata(mem_rdata), .dout(dout), .stall(stall), .slv_en(slv_en),
    .slv_rd(slv_rd), .slv_wr(slv_wr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack), .err(err), .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  io_bus_ctrl #(.NSLV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .adr(adr4), .rd(rd4), .wr(wr4), .din(32'h0),
    .mem_rdata(32'h0), .dout(dout4), .stall(stall4), .slv_en(slv_en4),
    .slv_rd(slv_rd4), .slv_wr(slv_wr4), .slv_wdata(slv_wdata4),
    .slv_rdata(slv_rdata4), .slv_ack(slv_ack4), .err(err4), .err_clr(err_clr4),
    .err_cnt(err_cnt4)
  );

  // Runs one I/O access on dut; entered and left at posedge+1.
  // ack_cyc counts ACCESS cycles from 1 (0 = never ack); stray < 0 = no stray ack.
  task automatic run_io(input logic [23:0] a, input logic w, input logic [31:0] d,
                        input int ack_slot, input int ack_cyc,
                        input logic [31:0] ack_data, input int stray);
    adr = a; rd = !w; wr = w; din = d;
    n_stall = 0; finished = 1'b0; done_dout = 'x;
    seen_en = '0; seen_rd = 1'b0; seen_wr = 1'b0; seen_wdata = '0;
    for (int c = 0; c < 40 && !finished; c++) begin
      slv_ack = '0;
      if (stray >= 0 && c >= 1) slv_ack[stray] = 1'b1;
      if (ack_cyc > 0 && c == ack_cyc) begin
        slv_ack[ack_slot] = 1'b1;
        slv_rdata[ack_slot*32 +: 32] = ack_data;
      end
      #1;
      if (!stall) begin
        finished  = 1'b1;
        done_dout = dout;
      end else begin
        n_stall++;
        if (slv_en != 0) begin
          seen_en = slv_en; seen_rd = slv_rd; seen_wr = slv_wr; seen_wdata = slv_wdata;
        end
        @(posedge clk); #1;
      end
    end
    rd = 1'b0; wr = 1'b0; slv_ack = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; adr = '0; rd = 0; wr = 0; din = '0; mem_rdata = 32'h11112222;
    slv_rdata = '0; slv_ack = '0; err_clr = 0;
    adr4 = '0; rd4 = 0; wr4 = 0; err_clr4 = 0; slv_rdata4 = '0; slv_ack4 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_checks++; if (slv_en !== 16'h0 || slv_rd !== 1'b0 || slv_wr !== 1'b0) begin n_fail++;
      $display("FAIL reset_strobes got en=%h rd=%b wr=%b exp 0", slv_en, slv_rd, slv_wr); end
    n_checks++; if (slv_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", slv_wdata); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 8'h0) begin n_fail++;
      $display("FAIL reset_err got err=%b cnt=%h exp 0/00", err, err_cnt); end
    n_checks++; if (dout !== 32'h11112222) begin n_fail++; $display("FAIL reset_dout got=%h exp=11112222", dout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ram;
    logic [23:0] ram_adr [3] = '{24'h000100, 24'hFFFF3C, 24'h000200};
    logic [31:0] ram_dat [3] = '{32'h12345678, 32'h89ABCDEF, 32'h0F0F0F0F};
    for (int i = 0; i < 3; i++) begin
      adr = ram_adr[i]; mem_rdata = ram_dat[i]; rd = (i != 2); wr = (i == 2);
      for (int c = 0; c < 2; c++) begin
        #1;
        n_checks++; if (dout !== ram_dat[i]) begin n_fail++; $display("FAIL ram_dout[%0d] got=%h exp=%h", i, dout, ram_dat[i]); end
        n_checks++; if (stall !== 1'b0 || slv_en !== 16'h0) begin n_fail++;
          $display("FAIL ram_stall[%0d] got stall=%b en=%h exp 0/0000", i, stall, slv_en); end
        @(posedge clk); #1;
      end
    end
    rd = 0; wr = 0;
  endtask

  task automatic test_read;
    run_io(24'hFFFFC8, 1'b0, 32'h0, 2, 2, 32'hCAFEF00D, -1);
    n_checks++; if (n_stall !== 3) begin n_fail++; $display("FAIL read_stall_cycles got=%0d exp=3", n_stall); end
    n_checks++; if (seen_en !== 16'h0004 || seen_rd !== 1'b1 || seen_wr !== 1'b0) begin n_fail++;
      $display("FAIL read_select got en=%h rd=%b wr=%b exp 0004/1/0", seen_en, seen_rd, seen_wr); end
    n_checks++; if (done_dout !== 32'hCAFEF00D) begin n_fail++; $display("FAIL read_dout got=%h exp=cafef00d", done_dout); end
    n_checks++; if (slv_en !== 16'h0 || stall !== 1'b0) begin n_fail++;
      $display("FAIL read_idle got en=%h stall=%b exp 0000/0", slv_en, stall); end
  endtask

  task automatic test_write;
    run_io(24'hFFFFC4, 1'b1, 32'h000000A5, 1, 1, 32'hDEADBEEF, -1);
    n_checks++; if (n_stall !== 2) begin n_fail++; $display("FAIL write_stall_cycles got=%0d exp=2", n_stall); end
    n_checks++; if (seen_en !== 16'h0002 || seen_wr !== 1'b1 || seen_rd !== 1'b0) begin n_fail++;
      $display("FAIL write_select got en=%h wr=%b rd=%b exp 0002/1/0", seen_en, seen_wr, seen_rd); end
    n_checks++; if (seen_wdata !== 32'h000000A5) begin n_fail++; $display("FAIL write_wdata got=%h exp=000000a5", seen_wdata); end
    n_checks++; if (done_dout !== 32'hCAFEF00D) begin n_fail++; $display("FAIL write_rdata_kept got=%h exp=cafef00d", done_dout); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err got=%b exp=0", err); end
  endtask

  task automatic test_timeout;
    run_io(24'hFFFFD4, 1'b0, 32'h0, 5, 0, 32'h0, 3);
    n_checks++; if (n_stall !== 17) begin n_fail++; $display("FAIL timeout_stall_cycles got=%0d exp=17", n_stall); end
    n_checks++; if (done_dout !== 32'h0) begin n_fail++; $display("FAIL timeout_dout got=%h exp=0", done_dout); end
    n_checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++;
      $display("FAIL timeout_err got err=%b cnt=%h exp 1/01", err, err_cnt); end
  endtask

  task automatic test_ack_on_last;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++;
      $display("FAIL err_clr got err=%b cnt=%h exp 0/00", err, err_cnt); end
    run_io(24'hFFFFC8, 1'b0, 32'h0, 2, 16, 32'h5A5A1234, -1);
    n_checks++; if (n_stall !== 17) begin n_fail++; $display("FAIL last_ack_stall_cycles got=%0d exp=17", n_stall); end
    n_checks++; if (done_dout !== 32'h5A5A1234) begin n_fail++; $display("FAIL last_ack_dout got=%h exp=5a5a1234", done_dout); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++;
      $display("FAIL last_ack_err got err=%b cnt=%h exp 0/00", err, err_cnt); end
  endtask

  task automatic test_unimpl;
    for (int i = 1; i <= 257; i++) begin
      adr4 = 24'hFFFFE4; rd4 = 1'b1;
      #1;
      if (i == 1) begin
        n_checks++; if (stall4 !== 1'b1 || slv_en4 !== 4'h0) begin n_fail++;
          $display("FAIL unimpl_idle got stall=%b en=%h exp 1/0", stall4, slv_en4); end
      end
      @(posedge clk); #1;
      if (i == 1) begin
        n_checks++; if (stall4 !== 1'b0 || dout4 !== 32'h0) begin n_fail++;
          $display("FAIL unimpl_done got stall=%b dout=%h exp 0/0", stall4, dout4); end
      end
      rd4 = 1'b0;
      @(posedge clk); #1;
      if (i == 1 || i == 256 || i == 257) begin
        n_checks++;
        if (err4 !== 1'b1 || err_cnt4 !== ((i == 1) ? 8'd1 : 8'hFF)) begin n_fail++;
          $display("FAIL unimpl_cnt[%0d] got err=%b cnt=%h exp 1/%h", i, err4, err_cnt4, (i == 1) ? 8'd1 : 8'hFF); end
      end
    end
    err_clr4 = 1'b1;
    @(posedge clk); #1;
    err_clr4 = 1'b0;
    n_checks++; if (err4 !== 1'b0 || err_cnt4 !== 8'd0) begin n_fail++;
      $display("FAIL unimpl_clr got err=%b cnt=%h exp 0/00", err4, err_cnt4); end
    err_clr4 = 1'b1; adr4 = 24'hFFFFE4; rd4 = 1'b1;
    @(posedge clk); #1;
    err_clr4 = 1'b0; rd4 = 1'b0;
    n_checks++; if (err4 !== 1'b1 || err_cnt4 !== 8'd1) begin n_fail++;
      $display("FAIL clr_vs_err got err=%b cnt=%h exp 1/01", err4, err_cnt4); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access;
    adr = 24'hFFFFC8; rd = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (slv_en !== 16'h0004 || slv_rd !== 1'b1) begin n_fail++;
      $display("FAIL mid_access got en=%h rd=%b exp 0004/1", slv_en, slv_rd); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (slv_en !== 16'h0 || slv_rd !== 1'b0 || slv_wr !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset_strobes got en=%h rd=%b wr=%b exp 0", slv_en, slv_rd, slv_wr); end
    rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (stall !== 1'b0 || slv_en !== 16'h0) begin n_fail++;
      $display("FAIL post_reset got stall=%b en=%h exp 0/0000", stall, slv_en); end
    run_io(24'hFFFFC8, 1'b0, 32'h0, 2, 2, 32'hCAFEF00D, -1);
    n_checks++; if (n_stall !== 3 || done_dout !== 32'hCAFEF00D || seen_en !== 16'h0004) begin n_fail++;
      $display("FAIL post_reset_read got stall=%0d dout=%h en=%h exp 3/cafef00d/0004", n_stall, done_dout, seen_en); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_read();
    test_write();
    test_timeout();
    test_ack_on_last();
    test_unimpl();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
